// File: rtl/reg_file_mp.sv
// Multi-port register file: two async read ports, general/flag/in-data write ports,
// hard-wired zero register, optional write->read bypass and a sequenced clear sweep.
module reg_file_mp #(
  parameter int DW       = 16,
  parameter int DEPTH    = 16,
  parameter int ZERO_IDX = 0,
  parameter int FLAG_IDX = 3,
  parameter int IN_IDX   = 13,
  parameter int OUT_IDX  = 14,
  parameter int ACC_IDX  = 15,
  parameter int R1_RST   = 1024,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          flag_we,
  input  logic [DW-1:0] flag_d,
  input  logic          in_we,
  input  logic [DW-1:0] in_d,
  output logic [DW-1:0] acc_data,
  output logic [DW-1:0] out_data,
  input  logic          clr_req,
  output logic          clr_busy
);

  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_CLEAR = 1'b1;
  localparam logic [AW-1:0] ZERO_A  = AW'(ZERO_IDX);
  localparam logic [AW-1:0] FLAG_A  = AW'(FLAG_IDX);
  localparam logic [AW-1:0] IN_A    = AW'(IN_IDX);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

  logic [DW-1:0] rf [DEPTH];
  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic          in_hit;
  logic          gen_acc;

  function automatic logic [DW-1:0] rst_val(input int idx);
    return (idx == 1) ? DW'(R1_RST) : '0;
  endfunction

  assign clr_busy = (state == S_CLEAR);
  assign acc_data = rf[ACC_IDX];
  assign out_data = rf[OUT_IDX];

  // In-data port owns IN_IDX: a same-cycle general write there is dropped
  always_comb begin
    in_hit  = in_we && !clr_busy;
    gen_acc = we && !clr_busy && (wa != ZERO_A) && (wa != FLAG_A) &&
              !(in_hit && (wa == IN_A));
  end

  function automatic logic [DW-1:0] rd_mux(input logic [AW-1:0] ra);
    logic [DW-1:0] v;
    v = rf[ra];
    if (ra == ZERO_A)                              v = '0;
    else if ((BYPASS != 0) && gen_acc && (wa == ra)) v = wd;
    return v;
  endfunction

  always_comb begin
    rd0 = rd_mux(ra0);
    rd1 = rd_mux(ra1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) rf[i] <= rst_val(i);
    end else begin
      case (state)
        S_IDLE: begin
          if (clr_req) begin
            state <= S_CLEAR;
            cnt   <= '0;
          end
        end
        S_CLEAR: begin
          rf[cnt] <= rst_val(int'(cnt));
          if (cnt == LAST_A) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      if (gen_acc)                rf[wa]       <= wd;
      if (flag_we && !clr_busy)   rf[FLAG_IDX] <= flag_d;
      if (in_hit)                 rf[IN_IDX]   <= in_d;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: reset, bypass, protected regs, port priority,
// back-to-back writes, clear sweep and reset abort mid-sweep.
module tb_reg_file_mp;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  ra0, ra1, wa;
  logic [15:0] rd0, rd1, wd, flag_d, in_d, acc_data, out_data;
  logic        we, flag_we, in_we, clr_req, clr_busy;
  int total = 0;
  int bad   = 0;

  reg_file_mp dut (
    .clock(clock), .reset_n(reset_n), .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .we(we), .wa(wa), .wd(wd), .flag_we(flag_we), .flag_d(flag_d),
    .in_we(in_we), .in_d(in_d), .acc_data(acc_data), .out_data(out_data),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clock = ~clock;

  task automatic quiet();
    we = 0; wa = 0; wd = 0; flag_we = 0; flag_d = 0; in_we = 0; in_d = 0; clr_req = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; quiet(); ra0 = 4'd1; ra1 = 4'd0;
    repeat (2) @(negedge clock);
    #1;
    total++; if (rd0 !== 16'd1024) begin bad++; $display("FAIL rst_r1_low act=%h exp=%h", rd0, 16'd1024); end
    @(negedge clock); reset_n = 1;
    @(negedge clock); #1;
    total++; if (rd0 !== 16'd1024) begin bad++; $display("FAIL rst_r1 act=%h exp=%h", rd0, 16'd1024); end
    total++; if (acc_data !== 16'h0) begin bad++; $display("FAIL rst_acc act=%h exp=0", acc_data); end
    total++; if (out_data !== 16'h0) begin bad++; $display("FAIL rst_out act=%h exp=0", out_data); end
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL rst_busy act=%b exp=0", clr_busy); end
    total++; if (rd1 !== 16'h0) begin bad++; $display("FAIL rst_zero act=%h exp=0", rd1); end
  endtask

  task automatic test_write_bypass();
    @(negedge clock); we = 1; wa = 4'd15; wd = 16'hBEEF; ra0 = 4'd15; #1;
    total++; if (rd0 !== 16'hBEEF) begin bad++; $display("FAIL bypass_rd0 act=%h exp=BEEF", rd0); end
    total++; if (acc_data !== 16'h0) begin bad++; $display("FAIL acc_before act=%h exp=0", acc_data); end
    @(negedge clock); quiet(); #1;
    total++; if (acc_data !== 16'hBEEF) begin bad++; $display("FAIL acc_after act=%h exp=BEEF", acc_data); end
    total++; if (rd0 !== 16'hBEEF) begin bad++; $display("FAIL stored_rd0 act=%h exp=BEEF", rd0); end
  endtask

  task automatic test_protected();
    @(negedge clock); we = 1; wa = 4'd0; wd = 16'h1234; ra0 = 4'd0; ra1 = 4'd3; #1;
    total++; if (rd0 !== 16'h0) begin bad++; $display("FAIL zero_nobyp act=%h exp=0", rd0); end
    @(negedge clock); wa = 4'd3; #1;
    total++; if (rd1 !== 16'h0) begin bad++; $display("FAIL flag_gen_nobyp act=%h exp=0", rd1); end
    total++; if (rd0 !== 16'h0) begin bad++; $display("FAIL zero_after act=%h exp=0", rd0); end
    @(negedge clock); quiet(); flag_we = 1; flag_d = 16'h0001; #1;
    total++; if (rd1 !== 16'h0) begin bad++; $display("FAIL flag_kept act=%h exp=0", rd1); end
    @(negedge clock); quiet(); #1;
    total++; if (rd1 !== 16'h0001) begin bad++; $display("FAIL flag_write act=%h exp=0001", rd1); end
  endtask

  task automatic test_in_priority();
    @(negedge clock); in_we = 1; in_d = 16'hAAAA; we = 1; wa = 4'd13; wd = 16'h5555; ra0 = 4'd13; #1;
    total++; if (rd0 !== 16'h0) begin bad++; $display("FAIL in_nobyp act=%h exp=0", rd0); end
    @(negedge clock); quiet(); #1;
    total++; if (rd0 !== 16'hAAAA) begin bad++; $display("FAIL in_wins act=%h exp=AAAA", rd0); end
  endtask

  task automatic test_back_to_back();
    @(negedge clock); we = 1; wa = 4'd5; wd = 16'h1111; ra0 = 4'd5; ra1 = 4'd6; #1;
    total++; if (rd0 !== 16'h1111) begin bad++; $display("FAIL b2b_0 act=%h exp=1111", rd0); end
    @(negedge clock); wa = 4'd6; wd = 16'h2222; #1;
    total++; if (rd0 !== 16'h1111) begin bad++; $display("FAIL b2b_1a act=%h exp=1111", rd0); end
    total++; if (rd1 !== 16'h2222) begin bad++; $display("FAIL b2b_1b act=%h exp=2222", rd1); end
    @(negedge clock); wa = 4'd5; wd = 16'h3333; #1;
    total++; if (rd0 !== 16'h3333) begin bad++; $display("FAIL b2b_2 act=%h exp=3333", rd0); end
    @(negedge clock); quiet(); #1;
    total++; if (rd0 !== 16'h3333) begin bad++; $display("FAIL b2b_3a act=%h exp=3333", rd0); end
    total++; if (rd1 !== 16'h2222) begin bad++; $display("FAIL b2b_3b act=%h exp=2222", rd1); end
  endtask

  task automatic test_clear();
    int busy_n;
    for (int i = 1; i < 16; i++) begin
      if (i != 3 && i != 13) begin
        @(negedge clock); we = 1; wa = 4'(i); wd = 16'h1000 + 16'(i);
      end
    end
    @(negedge clock); quiet(); clr_req = 1;
    @(negedge clock); clr_req = 0;
    we = 1; wa = 4'd5; wd = 16'hFFFF; flag_we = 1; flag_d = 16'hFFFF; in_we = 1; in_d = 16'hFFFF;
    ra0 = 4'd5; #1;
    total++; if (clr_busy !== 1'b1) begin bad++; $display("FAIL clr_start act=%b exp=1", clr_busy); end
    total++; if (rd0 !== 16'h1005) begin bad++; $display("FAIL clr_nobyp act=%h exp=1005", rd0); end
    busy_n = clr_busy ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock); #1;
      if (!clr_busy) break;
      busy_n++;
      if (busy_n == 2) begin
        total++; if (out_data !== 16'h100E) begin bad++; $display("FAIL clr_mid_out act=%h exp=100E", out_data); end
      end
      if (busy_n == 16) begin
        total++; if (acc_data !== 16'h100F) begin bad++; $display("FAIL clr_last_acc act=%h exp=100F", acc_data); end
        total++; if (out_data !== 16'h0) begin bad++; $display("FAIL clr_last_out act=%h exp=0", out_data); end
      end
    end
    quiet();
    total++; if (busy_n !== 16) begin bad++; $display("FAIL clr_len act=%0d exp=16", busy_n); end
    for (int i = 0; i < 16; i++) begin
      ra0 = 4'(i); #1;
      total++;
      if (rd0 !== ((i == 1) ? 16'd1024 : 16'd0)) begin
        bad++; $display("FAIL clr_end_r%0d act=%h exp=%h", i, rd0, (i == 1) ? 16'd1024 : 16'd0);
      end
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clock); we = 1; wa = 4'd14; wd = 16'h00FF;
    @(negedge clock); quiet(); clr_req = 1;
    @(negedge clock); clr_req = 0;
    repeat (4) @(negedge clock);
    #1;
    total++; if (out_data !== 16'h00FF) begin bad++; $display("FAIL abort_pre_out act=%h exp=00FF", out_data); end
    total++; if (clr_busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy act=%b exp=1", clr_busy); end
    reset_n = 0; ra0 = 4'd1; ra1 = 4'd14; #1;
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL abort_busy act=%b exp=0", clr_busy); end
    total++; if (out_data !== 16'h0) begin bad++; $display("FAIL abort_out act=%h exp=0", out_data); end
    total++; if (rd0 !== 16'd1024) begin bad++; $display("FAIL abort_r1 act=%h exp=%h", rd0, 16'd1024); end
    @(negedge clock); reset_n = 1;
    @(negedge clock); #1;
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL abort_idle act=%b exp=0", clr_busy); end
    total++; if (rd1 !== 16'h0) begin bad++; $display("FAIL abort_r14 act=%h exp=0", rd1); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_protected();
    test_in_priority();
    test_back_to_back();
    test_clear();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
